// File: rtl/cmp_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cmp_config_loader_pkg
// Brief    : Shared salt range, salt type and selector-width helper.
// Revision : 1.0
// ============================================================================
package cmp_config_loader_pkg;

    localparam int c_salt_msb = 11;
    localparam int c_salt_lsb = 0;

    typedef logic [c_salt_msb:c_salt_lsb] salt_t;

    // A unit selector needs at least one bit even when there is a single unit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_rr_addr.sv
`default_nettype none
// ============================================================================
// Module   : cmp_rr_addr
// Brief    : Round-robin unit selector with per-wrap address increment.
// Revision : 1.0
// ============================================================================
module cmp_rr_addr
    import cmp_config_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter int DEPTH_MSB = 7
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [N-1:0]       o_unit,
    output logic [DEPTH_MSB:0] o_addr
);

    localparam int c_sel_w = sel_width(N);
    localparam logic [c_sel_w-1:0] c_last = c_sel_w'(N - 1);

    logic [c_sel_w-1:0] r_sel;
    logic [DEPTH_MSB:0] r_addr;

    always_ff @(posedge CLK) begin
        if (RESET || i_clear) begin
            r_sel  <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (r_sel == c_last) begin
                r_sel  <= '0;
                r_addr <= r_addr + 1'b1;
            end else begin
                r_sel  <= r_sel + 1'b1;
            end
        end
    end

    assign o_unit = N'(1) << r_sel;
    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/cmp_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : cmp_config_loader
// Brief    : Loads a salt and hash list round-robin into N comparator units.
// Revision : 1.0
// ============================================================================
module cmp_config_loader
    import cmp_config_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter int DEPTH_MSB = 7,
    parameter int HASH_W    = 35,
    parameter int CNT_MSB   = 11
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [c_salt_msb:c_salt_lsb] cfg_salt,
    input  logic [CNT_MSB:0]             cfg_num_hashes,
    input  logic                         hash_valid,
    output logic                         hash_ready,
    input  logic [HASH_W-1:0]            hash_data,
    output logic [N-1:0]                 unit_wr_en,
    output logic [DEPTH_MSB:0]           unit_wr_addr,
    output logic [HASH_W-1:0]            unit_wr_data,
    output logic [c_salt_msb:c_salt_lsb] global_salt,
    output logic [DEPTH_MSB:0]           num_hashes,
    output logic [sel_width(N)-1:0]      num_hashes_remain,
    output logic                         new_cmp_config,
    input  logic                         all_cmp_config_applied,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int c_sel_w = sel_width(N);
    localparam int c_log2n = $clog2(N);
    localparam logic [CNT_MSB+1:0] c_max_hashes = (CNT_MSB+2)'(N * (2 ** (DEPTH_MSB + 1)));
    localparam logic [CNT_MSB:0]   c_rem_mask   = (CNT_MSB+1)'(N - 1);
    localparam logic [CNT_MSB:0]   c_one        = (CNT_MSB+1)'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_start = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    logic [1:0]          r_state;
    logic                r_cfg_ready;
    logic                r_hash_ready;
    logic [CNT_MSB:0]    r_hash_left;
    logic [N-1:0]        r_unit_wr_en;
    logic [DEPTH_MSB:0]  r_unit_wr_addr;
    logic [HASH_W-1:0]   r_unit_wr_data;
    salt_t               r_global_salt;
    logic [DEPTH_MSB:0]  r_num_hashes;
    logic [c_sel_w-1:0]  r_num_remain;
    logic                r_new_cmp_config;
    logic                r_cfg_err;

    logic [CNT_MSB:0]    w_cnt_div;
    logic [CNT_MSB:0]    w_cnt_mod;
    logic                w_cnt_bad;
    logic                w_cfg_acc;
    logic                w_hash_acc;
    logic [N-1:0]        w_unit;
    logic [DEPTH_MSB:0]  w_addr;
    logic                w_unused;

    // N is a power of two, so divide/modulo reduce to shift and mask.
    assign w_cnt_div  = cfg_num_hashes >> c_log2n;
    assign w_cnt_mod  = cfg_num_hashes & c_rem_mask;
    assign w_cnt_bad  = (cfg_num_hashes == '0) || ({1'b0, cfg_num_hashes} > c_max_hashes);
    assign w_cfg_acc  = (r_state == c_st_idle) && cfg_valid && r_cfg_ready;
    assign w_hash_acc = (r_state == c_st_load) && hash_valid && r_hash_ready;
    assign w_unused   = ^{w_cnt_div[CNT_MSB:DEPTH_MSB+1], w_cnt_mod[CNT_MSB:c_sel_w]};

    cmp_rr_addr #(
        .N         (N),
        .DEPTH_MSB (DEPTH_MSB)
    ) u_rr_addr (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_clear   (w_cfg_acc && !w_cnt_bad),
        .i_advance (w_hash_acc),
        .o_unit    (w_unit),
        .o_addr    (w_addr)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state          <= c_st_idle;
            r_cfg_ready      <= 1'b0;
            r_hash_ready     <= 1'b0;
            r_hash_left      <= '0;
            r_unit_wr_en     <= '0;
            r_unit_wr_addr   <= '0;
            r_unit_wr_data   <= '0;
            r_global_salt    <= '0;
            r_num_hashes     <= '0;
            r_num_remain     <= '0;
            r_new_cmp_config <= 1'b0;
            r_cfg_err        <= 1'b0;
        end else begin
            r_unit_wr_en     <= '0;
            r_new_cmp_config <= 1'b0;
            r_cfg_err        <= 1'b0;

            if (w_hash_acc) begin
                r_unit_wr_en   <= w_unit;
                r_unit_wr_addr <= w_addr;
                r_unit_wr_data <= hash_data;
                r_hash_left    <= r_hash_left - c_one;
            end

            case (r_state)
                c_st_idle: begin
                    r_cfg_ready <= 1'b1;
                    if (w_cfg_acc) begin
                        if (w_cnt_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_global_salt <= cfg_salt;
                            r_num_hashes  <= w_cnt_div[DEPTH_MSB:0];
                            r_num_remain  <= w_cnt_mod[c_sel_w-1:0];
                            r_hash_left   <= cfg_num_hashes;
                            r_cfg_ready   <= 1'b0;
                            r_hash_ready  <= 1'b1;
                            r_state       <= c_st_load;
                        end
                    end
                end
                c_st_load: begin
                    // The START pulse lines up with the final write strobe.
                    if (w_hash_acc && (r_hash_left == c_one)) begin
                        r_hash_ready     <= 1'b0;
                        r_new_cmp_config <= 1'b1;
                        r_state          <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (all_cmp_config_applied) begin
                        r_cfg_ready <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cfg_ready         = r_cfg_ready;
    assign hash_ready        = r_hash_ready;
    assign unit_wr_en        = r_unit_wr_en;
    assign unit_wr_addr      = r_unit_wr_addr;
    assign unit_wr_data      = r_unit_wr_data;
    assign global_salt       = r_global_salt;
    assign num_hashes        = r_num_hashes;
    assign num_hashes_remain = r_num_remain;
    assign new_cmp_config    = r_new_cmp_config;
    assign busy              = (r_state != c_st_idle);
    assign cfg_err           = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_cmp_config_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmp_config_loader
// Brief    : Directed self-checking bench for cmp_config_loader (N=4).
// Revision : 1.0
// ============================================================================
module tb_cmp_config_loader;
    import cmp_config_loader_pkg::*;

    localparam int N         = 4;
    localparam int DEPTH_MSB = 7;
    localparam int HASH_W    = 35;
    localparam int CNT_MSB   = 11;
    localparam int c_budget  = 50;

    logic                         CLK = 1'b0;
    logic                         RESET = 1'b1;
    logic                         cfg_valid = 1'b0;
    logic                         cfg_ready;
    logic [c_salt_msb:c_salt_lsb] cfg_salt = '0;
    logic [CNT_MSB:0]             cfg_num_hashes = '0;
    logic                         hash_valid = 1'b0;
    logic                         hash_ready;
    logic [HASH_W-1:0]            hash_data = '0;
    logic [N-1:0]                 unit_wr_en;
    logic [DEPTH_MSB:0]           unit_wr_addr;
    logic [HASH_W-1:0]            unit_wr_data;
    logic [c_salt_msb:c_salt_lsb] global_salt;
    logic [DEPTH_MSB:0]           num_hashes;
    logic [sel_width(N)-1:0]      num_hashes_remain;
    logic                         new_cmp_config;
    logic                         all_cmp_config_applied = 1'b0;
    logic                         busy;
    logic                         cfg_err;

    cmp_config_loader #(
        .N(N), .DEPTH_MSB(DEPTH_MSB), .HASH_W(HASH_W), .CNT_MSB(CNT_MSB)
    ) dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_salt               (cfg_salt),
        .cfg_num_hashes         (cfg_num_hashes),
        .hash_valid             (hash_valid),
        .hash_ready             (hash_ready),
        .hash_data              (hash_data),
        .unit_wr_en             (unit_wr_en),
        .unit_wr_addr           (unit_wr_addr),
        .unit_wr_data           (unit_wr_data),
        .global_salt            (global_salt),
        .num_hashes             (num_hashes),
        .num_hashes_remain      (num_hashes_remain),
        .new_cmp_config         (new_cmp_config),
        .all_cmp_config_applied (all_cmp_config_applied),
        .busy                   (busy),
        .cfg_err                (cfg_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                u_idx;
        int                addr;
        logic [HASH_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];
    int  cyc         = 0;
    int  n_checks    = 0;
    int  n_errors    = 0;
    int  n_wr        = 0;
    int  n_ncc       = 0;
    int  last_wr_cyc = -1;
    int  ncc_cyc     = -2;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HASH_W-1:0] hval(input int cfg, input int k);
        return {3'(cfg), 32'hC0DE_0000 + 32'(k * 17)};
    endfunction

    // Write scoreboard: each observed strobe must match the oldest accepted hash.
    always @(negedge CLK) begin
        if (unit_wr_en != '0) begin
            wr_t e;
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(unit_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_en",   64'(unit_wr_en),   64'd1 << e.u_idx);
                check("wr_addr", 64'(unit_wr_addr), 64'(e.addr));
                check("wr_data", 64'(unit_wr_data), 64'(e.data));
                check("wr_cyc",  64'(cyc),          64'(e.cyc));
            end
        end
        if (new_cmp_config == 1'b1) begin
            n_ncc++;
            ncc_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_header(input logic [11:0] salt, input int cnt);
        int b;
        cfg_valid      = 1'b1;
        cfg_salt       = salt;
        cfg_num_hashes = 12'(cnt);
        b = 0;
        while (!cfg_ready && b < c_budget) begin
            tick();
            b++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", 64'd0, 64'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic load_hashes(input int cfg, input int n, input int gap, input int stray_at);
        int b;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                all_cmp_config_applied = (k == stray_at) && (g == 0);
                hash_valid = 1'b0;
                hash_data  = '1;
                tick();
            end
            all_cmp_config_applied = 1'b0;
            hash_valid = 1'b1;
            hash_data  = hval(cfg, k);
            b = 0;
            while (!hash_ready && b < c_budget) begin
                tick();
                b++;
            end
            if (!hash_ready) check("hash_ready_timeout", 64'd0, 64'd1);
            tick();
            exp_q.push_back('{k % N, k / N, hval(cfg, k), cyc});
        end
        hash_valid = 1'b0;
        hash_data  = '0;
    endtask

    task automatic end_load();
        check("ncc_at_last_wr", 64'(new_cmp_config), 64'd1);
        check("hash_ready_off", 64'(hash_ready),     64'd0);
        tick();
        check("ncc_one_cycle",  64'(new_cmp_config), 64'd0);
        check("busy_in_wait",   64'(busy),           64'd1);
        check("ncc_vs_wr_cyc",  64'(ncc_cyc),        64'(last_wr_cyc));
    endtask

    task automatic apply();
        all_cmp_config_applied = 1'b1;
        tick();
        all_cmp_config_applied = 1'b0;
        check("busy_after_apply",  64'(busy),      64'd0);
        check("ready_after_apply", 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_cfg_ready",  64'(cfg_ready),         64'd0);
        check("rst_hash_ready", 64'(hash_ready),        64'd0);
        check("rst_busy",       64'(busy),              64'd0);
        check("rst_wr_en",      64'(unit_wr_en),        64'd0);
        check("rst_salt",       64'(global_salt),       64'd0);
        check("rst_num",        64'(num_hashes),        64'd0);
        check("rst_remain",     64'(num_hashes_remain), 64'd0);
        check("rst_ncc",        64'(new_cmp_config),    64'd0);
        check("rst_err",        64'(cfg_err),           64'd0);
        RESET = 1'b0;
        tick();
        check("idle_cfg_ready", 64'(cfg_ready), 64'd1);

        // Six hashes back-to-back: two full rounds minus two.
        send_header(12'h5A3, 6);
        check("t1_busy",       64'(busy),              64'd1);
        check("t1_hash_ready", 64'(hash_ready),        64'd1);
        check("t1_cfg_ready",  64'(cfg_ready),         64'd0);
        check("t1_salt",       64'(global_salt),       64'h5A3);
        check("t1_num",        64'(num_hashes),        64'd1);
        check("t1_remain",     64'(num_hashes_remain), 64'd2);
        load_hashes(1, 6, 0, -1);
        end_load();
        apply();

        // Single hash.
        send_header(12'h0F1, 1);
        check("t2_num",    64'(num_hashes),        64'd0);
        check("t2_remain", 64'(num_hashes_remain), 64'd1);
        load_hashes(2, 1, 0, -1);
        end_load();
        check("t2_busy_before_apply", 64'(busy), 64'd1);
        apply();

        // Rejected headers: zero and one above capacity.
        send_header(12'h777, 0);
        check("t3a_err",   64'(cfg_err),     64'd1);
        check("t3a_busy",  64'(busy),        64'd0);
        check("t3a_ready", 64'(cfg_ready),   64'd1);
        check("t3a_salt",  64'(global_salt), 64'h0F1);
        check("t3a_num",   64'(num_hashes),  64'd0);
        tick();
        check("t3a_err_pulse", 64'(cfg_err), 64'd0);
        send_header(12'h778, N * 256 + 1);
        check("t3b_err",    64'(cfg_err),           64'd1);
        check("t3b_busy",   64'(busy),              64'd0);
        check("t3b_salt",   64'(global_salt),       64'h0F1);
        check("t3b_remain", 64'(num_hashes_remain), 64'd1);
        tick();
        check("t3b_err_pulse", 64'(cfg_err), 64'd0);
        check("t3b_busy2",     64'(busy),    64'd0);

        // Gapped stream with a stray applied pulse mid-load.
        send_header(12'h123, 8);
        check("t4_num",    64'(num_hashes),        64'd2);
        check("t4_remain", 64'(num_hashes_remain), 64'd0);
        load_hashes(3, 8, 2, 3);
        end_load();

        // Header presented in WAIT must wait for the applied pulse.
        cfg_valid      = 1'b1;
        cfg_salt       = 12'h456;
        cfg_num_hashes = 12'd1;
        tick();
        check("t4_wait_ready", 64'(cfg_ready),   64'd0);
        check("t4_wait_busy",  64'(busy),        64'd1);
        tick();
        check("t4_wait_salt",  64'(global_salt), 64'h123);
        apply();
        check("t4_salt_kept",  64'(global_salt), 64'h123);
        tick();
        cfg_valid = 1'b0;
        check("t4b_busy", 64'(busy),        64'd1);
        check("t4b_salt", 64'(global_salt), 64'h456);
        load_hashes(4, 1, 0, -1);
        end_load();
        apply();

        // Reset in the middle of a load.
        send_header(12'h9AB, 6);
        load_hashes(5, 3, 0, -1);
        hash_valid = 1'b1;
        hash_data  = hval(5, 3);
        RESET = 1'b1;
        tick();
        RESET      = 1'b0;
        hash_valid = 1'b0;
        check("t5_cfg_ready",  64'(cfg_ready),         64'd0);
        check("t5_hash_ready", 64'(hash_ready),        64'd0);
        check("t5_busy",       64'(busy),              64'd0);
        check("t5_wr_en",      64'(unit_wr_en),        64'd0);
        check("t5_wr_addr",    64'(unit_wr_addr),      64'd0);
        check("t5_wr_data",    64'(unit_wr_data),      64'd0);
        check("t5_salt",       64'(global_salt),       64'd0);
        check("t5_num",        64'(num_hashes),        64'd0);
        check("t5_remain",     64'(num_hashes_remain), 64'd0);
        check("t5_ncc",        64'(new_cmp_config),    64'd0);
        check("t5_pending",    64'(exp_q.size()),      64'd0);
        tick();
        check("t5_ready_back", 64'(cfg_ready), 64'd1);
        send_header(12'h321, 1);
        check("t5b_salt", 64'(global_salt), 64'h321);
        load_hashes(6, 1, 0, -1);
        end_load();
        apply();

        tick();
        tick();
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
        check("write_count",     64'(n_wr),         64'd20);
        check("ncc_count",       64'(n_ncc),        64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_config_loader.md
# cmp_config_loader

Sequences loading of a new comparator configuration into N comparator units. Accepts a header (salt, hash count) and then a stream of hashes. Hashes are written round-robin into the units' hash memories. The loader then raises `new_cmp_config` toward the config distributor and waits for `all_cmp_config_applied` before accepting the next configuration. It sits between the host-side input FIFO and the comparator config distributor.

## Interface
- N, 4 — number of comparator units; power of 2, 1..16.
- DEPTH_MSB, 7 — MSB of per-unit hash address; each unit holds 2^(DEPTH_MSB+1) hashes.
- HASH_W, 35 — hash word width.
- CNT_MSB, 11 — MSB of header hash count.
- CLK  in  1 — clock.
- RESET  in  1 — synchronous, active-high reset.
- cfg_valid  in  1 — header valid.
- cfg_ready  out  1 — header accepted when valid & ready; reset 0 (1 from first cycle after reset).
- cfg_salt  in  `GLOBAL_SALT_MSB:`GLOBAL_SALT_LSB — salt for this configuration.
- cfg_num_hashes  in  CNT_MSB+1 — number of hashes that follow.
- hash_valid / hash_ready  in / out  1 — hash stream handshake; hash_ready reset 0.
- hash_data  in  HASH_W — hash word.
- unit_wr_en  out  N — one-hot write strobe; reset 0.
- unit_wr_addr  out  DEPTH_MSB+1 — address within the unit; reset 0.
- unit_wr_data  out  HASH_W — registered hash; reset 0.
- global_salt  out  salt range — latched salt, to distributor `global_salt_in`; reset 0.
- num_hashes  out  DEPTH_MSB+1 — cfg_num_hashes / N; reset 0.
- num_hashes_remain  out  log2(N) (min 1) — cfg_num_hashes mod N; reset 0.
- new_cmp_config  out  1 — 1-cycle pulse; reset 0.
- all_cmp_config_applied  in  1 — 1-cycle pulse from distributor.
- busy  out  1 — state != IDLE; reset 0.
- cfg_err  out  1 — 1-cycle pulse on rejected header; reset 0.

## Operation
- States: IDLE, LOAD, START, WAIT.
- IDLE:
  - cfg_ready=1.
  - On header accept, if count==0 or count > N·2^(DEPTH_MSB+1): pulse cfg_err next cycle, stay IDLE, leave outputs unchanged.
  - Otherwise latch global_salt, num_hashes and num_hashes_remain, clear the index counter, and go to LOAD.
- LOAD:
  - hash_ready=1 while remaining > 0.
  - Hash k (0-based) goes to unit k mod N, address k / N. The next cycle drives unit_wr_en[k mod N]=1 and unit_wr_data=hash.
  - The unit selector and address are counters: the unit wraps N-1→0, and the address increments on each wrap.
  - After the last hash is accepted, hash_ready=0 in the same cycle's registered output, and the state goes to START.
- START: new_cmp_config=1 for exactly one cycle, then WAIT.
- WAIT: on all_cmp_config_applied=1 go to IDLE; cfg_ready=1 on the next cycle.
- all_cmp_config_applied is ignored outside WAIT.
- hash_valid is ignored outside LOAD.
- RESET in any state: return to IDLE and clear all registered outputs. A partial load is abandoned with no further writes. The previous salt is discarded (global_salt=0).

## Timing
- Header accepted at cycle T → busy=1 and hash_ready=1 at T+1.
- Hash accepted at cycle t → write strobe at t+1. With back-to-back valid, one write per cycle.
- Last hash accepted at cycle L:
  - last write at L+1;
  - new_cmp_config=1 at L+1, coincident with the last write, because the state is START at L+1;
  - hash_ready=0 from L+1.
- all_cmp_config_applied at cycle A → busy=0 and cfg_ready=1 at A+1. Minimum header-to-header spacing = count + 3 cycles.
- Widths: the count compare uses CNT_MSB+2 bits, so N·depth must not overflow. num_hashes and remain come from shift and mask (N is a power of 2).

## Structure
- Salt range (`GLOBAL_SALT_MSB/LSB`) and hash width macros live in the shared `descrypt.vh` header. State encodings are localparams inside the module.
- One natural sub-module: `cmp_rr_addr`, the round-robin unit/address counter. Inputs: clear and advance. Outputs: one-hot unit and address.

## Test plan
- N=4, header salt=0x5A3 and count=6, hashes H0..H5 back-to-back:
  - writes unit0@0, unit1@0, unit2@0, unit3@0, unit0@1, unit1@1;
  - num_hashes=1, remain=2;
  - new_cmp_config coincides with the H5 write.
- count=1: a single write to unit0@0; new_cmp_config at L+1; busy drops the cycle after the all_cmp_config_applied pulse.
- count=0, then count=N·256+1: cfg_err pulses each time, busy stays 0, and no writes occur.
- Gapped hash_valid (1 of every 3 cycles, count=8): eight writes in order, with no write during gaps.
- Stray all_cmp_config_applied pulse during LOAD: ignored and the load completes. A second header presented during WAIT is not accepted until after the applied pulse.
- RESET asserted after 3 of 6 hashes: the next cycle shows all outputs 0 and state IDLE. A fresh header then restarts at unit0@0.
